// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: access size encoding, FSM states,
// fixed datapath widths and the alignment-check helper.
package memory_access_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } data_size_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input data_size_e size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus.
//   req   : request, held until ack          we    : 1 = write
//   addr  : word address (bits [1:0] = 0)    be    : byte enables
//   wdata : write data                       ack   : transaction complete
//   rdata : read word, valid with ack
// master = memory stage, slave = data memory.
interface memory_access_if;
  import memory_access_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/memory_access_lsu_align.sv
// lsu_align: purely combinational byte-lane formatting.
//   Store path: st_off, st_size, rs2          -> be, wdata
//   Load path : ld_off, ld_size, ld_unsigned,
//               rdata                          -> load_data
// Half accesses ignore offset bit 0 and word accesses ignore both offset
// bits, so a misaligned access targets the aligned-down location.
module lsu_align
  import memory_access_pkg::*;
(
  input  logic [1:0]      st_off,
  input  data_size_e      st_size,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  input  logic [1:0]      ld_off,
  input  data_size_e      ld_size,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  logic [1:0]      st_eff;
  logic [1:0]      ld_eff;
  logic [XLEN-1:0] shifted;
  logic            sign;

  always_comb begin
    st_eff = st_off;
    be     = 4'b1111;
    wdata  = rs2;
    case (st_size)
      SIZE_BYTE: begin
        be    = 4'b0001 << st_eff;
        wdata = {4{rs2[7:0]}};
      end
      SIZE_HALF: begin
        st_eff = {st_off[1], 1'b0};
        be     = st_eff[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{rs2[15:0]}};
      end
      default: begin
        st_eff = 2'b00;
        be     = 4'b1111;
        wdata  = rs2;
      end
    endcase
  end

  always_comb begin
    ld_eff    = ld_off;
    shifted   = '0;
    sign      = 1'b0;
    load_data = rdata;
    case (ld_size)
      SIZE_BYTE: begin
        shifted   = rdata >> {ld_eff, 3'b000};
        sign      = ~ld_unsigned & shifted[7];
        load_data = {{24{sign}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        ld_eff    = {ld_off[1], 1'b0};
        shifted   = rdata >> {ld_eff, 3'b000};
        sign      = ~ld_unsigned & shifted[15];
        load_data = {{16{sign}}, shifted[15:0]};
      end
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline memory stage.
//   clk, rst_n        : clock, synchronous active-low reset
//   sel_rd_i          : destination register (0 = no writeback)
//   mem_re_i/mem_we_i : load / store request (mutually exclusive)
//   mem_size_i        : access size, mem_unsigned_i: zero-extend loads
//   alu_result_i      : address for memory ops, writeback data otherwise
//   rs2_i             : store data
//   stall_o           : execute must hold (high for every WAIT cycle)
//   dmem              : data-memory bus (master side)
//   wb_rd_o/wb_data_o/wb_we_o : registered writeback bundle
//   misalign_o        : misaligned-access pulse
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses issue no
// request and pulse misalign_o; otherwise misalign_o is tied low.
module memory_access
  import memory_access_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] sel_rd_i,
  input  logic             mem_re_i,
  input  logic             mem_we_i,
  input  data_size_e       mem_size_i,
  input  logic             mem_unsigned_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  rs2_i,
  output logic             stall_o,
  memory_access_if.master  dmem,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             wb_we_o,
  output logic             misalign_o
);

  mem_state_e       state;
  mem_state_e       state_next;

  logic [XLEN-1:0]  req_addr;
  logic [1:0]       req_off;
  data_size_e       req_size;
  logic             req_unsigned;
  logic [REG_W-1:0] req_rd;
  logic             req_we;
  logic [3:0]       req_be;
  logic [XLEN-1:0]  req_wdata;

  logic [3:0]       cap_be;
  logic [XLEN-1:0]  cap_wdata;
  logic [XLEN-1:0]  load_data;

  logic             mem_op;
  logic             accept;

  assign mem_op = mem_re_i | mem_we_i;

`ifdef MEM_MISALIGN_TRAP_EN
  logic trap;
  logic misalign_q;

  assign trap   = mem_op & is_misaligned(mem_size_i, alu_result_i[1:0]);
  assign accept = mem_op & ~trap;

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= (state == MEM_IDLE) & trap;
  end

  assign misalign_o = misalign_q;
`else
  assign accept     = mem_op;
  assign misalign_o = 1'b0;
`endif

  lsu_align u_align (
    .st_off      (alu_result_i[1:0]),
    .st_size     (mem_size_i),
    .rs2         (rs2_i),
    .be          (cap_be),
    .wdata       (cap_wdata),
    .ld_off      (req_off),
    .ld_size     (req_size),
    .ld_unsigned (req_unsigned),
    .rdata       (dmem.rdata),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MEM_IDLE: if (accept)   state_next = MEM_WAIT;
      MEM_WAIT: if (dmem.ack) state_next = MEM_IDLE;
      default:                state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr     <= '0;
      req_off      <= '0;
      req_size     <= SIZE_BYTE;
      req_unsigned <= 1'b0;
      req_rd       <= '0;
      req_we       <= 1'b0;
      req_be       <= '0;
      req_wdata    <= '0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      wb_we_o      <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (!mem_op) begin
            wb_rd_o   <= sel_rd_i;
            wb_data_o <= alu_result_i;
            wb_we_o   <= (sel_rd_i != '0);
          end else begin
            wb_we_o <= 1'b0;
            if (accept) begin
              req_addr     <= {alu_result_i[XLEN-1:2], 2'b00};
              req_off      <= alu_result_i[1:0];
              req_size     <= mem_size_i;
              req_unsigned <= mem_unsigned_i;
              req_rd       <= sel_rd_i;
              req_we       <= mem_we_i;
              req_be       <= cap_be;
              req_wdata    <= cap_wdata;
            end
          end
        end
        MEM_WAIT: begin
          wb_we_o <= 1'b0;
          if (dmem.ack && !req_we) begin
            wb_rd_o   <= req_rd;
            wb_data_o <= load_data;
            wb_we_o   <= (req_rd != '0);
          end
        end
        default: wb_we_o <= 1'b0;
      endcase
    end
  end

  // stall is a function of state only; the rst_n gate keeps it low while
  // reset is held even before the reset edge has cleared the state.
  assign stall_o    = (state == MEM_WAIT) & rst_n;
  assign dmem.req   = (state == MEM_WAIT);
  assign dmem.we    = req_we;
  assign dmem.addr  = req_addr;
  assign dmem.be    = req_be;
  assign dmem.wdata = req_wdata;

endmodule
